// File: rtl/bus_port_fifo_if.sv
// Bus port interface: groups the device-side TX/RX handshakes and the
// arbiter-side pndng/D_pop/pop and push/D_push signals of one bus port.
//   slave  : the port buffer (bus_port_fifo) view.
//   master : the driving environment (device agent plus arbiter) view.
// Optional macro DEST_CHECK_EN adds the sticky misroute flag.
interface bus_port_fifo_if #(
    parameter int unsigned pckg_sz = 24
);
    logic               wr_en;
    logic [pckg_sz-1:0] wr_data;
    logic               tx_full;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rx_rd;
    logic               rx_valid;
    logic [pckg_sz-1:0] rx_data;
    logic               tx_ovf;
    logic               rx_ovf;
    logic               clr_flags;
`ifdef DEST_CHECK_EN
    logic               misroute;
`endif

    modport slave (
        input  wr_en, wr_data, pop, push, D_push, rx_rd, clr_flags,
        output tx_full, pndng, D_pop, rx_valid, rx_data, tx_ovf, rx_ovf
`ifdef DEST_CHECK_EN
        , output misroute
`endif
    );

    modport master (
        output wr_en, wr_data, pop, push, D_push, rx_rd, clr_flags,
        input  tx_full, pndng, D_pop, rx_valid, rx_data, tx_ovf, rx_ovf
`ifdef DEST_CHECK_EN
        , input misroute
`endif
    );
endinterface

// File: rtl/bus_port_fifo.sv
// Per-device bus port buffer.
//   TX FIFO: device writes (wr_en/wr_data), arbiter sees pndng/D_pop and consumes with pop.
//   RX FIFO: bus delivers with push/D_push (no backpressure), device drains with rx_rd and
//            sees rx_valid/rx_data.
//   tx_ovf/rx_ovf: sticky drop flags, cleared by clr_flags (a same-cycle drop wins).
// Both FIFOs are first-word fall-through; head outputs read 0 when empty.
// Ports: clk, reset (async, active-high), bus (bus_port_fifo_if.slave).
// Optional macro DEST_CHECK_EN: deliveries whose destination ID matches neither id nor bc
// are discarded and raise the sticky misroute flag instead of being stored.
module bus_port_fifo #(
    parameter int unsigned pckg_sz = 24,
    parameter int unsigned depth   = 8,
    parameter logic [7:0]  id      = 8'h00,
    parameter logic [7:0]  bc      = 8'hFF
) (
    input logic            clk,
    input logic            reset,
    bus_port_fifo_if.slave bus
);
    localparam int unsigned PtrW = $clog2(depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(depth);

    // ---------------- TX side ----------------
    logic [pckg_sz-1:0] tx_mem_q [depth];
    logic [PtrW-1:0]    tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PtrW-1:0]    tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CntW-1:0]    tx_cnt_q, tx_cnt_d;
    logic               tx_full_q, tx_full_d;
    logic               tx_ovf_q, tx_ovf_d;
    logic               tx_nonempty, tx_push, tx_pop;

    always_comb begin
        tx_nonempty = (tx_cnt_q != '0);
        tx_pop      = bus.pop && tx_nonempty;
        // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
        tx_push     = bus.wr_en && (!tx_full_q || tx_pop);
        tx_wr_ptr_d = tx_wr_ptr_q + PtrW'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + PtrW'(tx_pop);
        tx_cnt_d    = tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
        tx_full_d   = (tx_cnt_d == DepthCnt);
        tx_ovf_d    = tx_ovf_q;
        if (bus.wr_en && !tx_push) begin
            tx_ovf_d = 1'b1;
        end else if (bus.clr_flags) begin
            tx_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            tx_full_q   <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_full_q   <= tx_full_d;
            tx_ovf_q    <= tx_ovf_d;
        end
    end

    // Storage needs no reset: the count decides what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.tx_full = tx_full_q;
    assign bus.pndng   = tx_nonempty;
    assign bus.D_pop   = tx_nonempty ? tx_mem_q[tx_rd_ptr_q] : '0;
    assign bus.tx_ovf  = tx_ovf_q;

    // ---------------- RX side ----------------
    logic [pckg_sz-1:0] rx_mem_q [depth];
    logic [PtrW-1:0]    rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PtrW-1:0]    rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CntW-1:0]    rx_cnt_q, rx_cnt_d;
    logic               rx_ovf_q, rx_ovf_d;
    logic               rx_nonempty, rx_full, rx_push, rx_pop, dest_ok;

`ifdef DEST_CHECK_EN
    logic misroute_q, misroute_d;
    assign dest_ok = (bus.D_push[pckg_sz-1 -: 8] == id) || (bus.D_push[pckg_sz-1 -: 8] == bc);
`else
    logic unused_dest_params;
    assign unused_dest_params = ^{id, bc};
    assign dest_ok = 1'b1;
`endif

    always_comb begin
        rx_nonempty = (rx_cnt_q != '0);
        rx_full     = (rx_cnt_q == DepthCnt);
        rx_pop      = bus.rx_rd && rx_nonempty;
        rx_push     = bus.push && dest_ok && (!rx_full || rx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + PtrW'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + PtrW'(rx_pop);
        rx_cnt_d    = rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
        rx_ovf_d    = rx_ovf_q;
        // A misrouted delivery is not an overflow, hence the dest_ok term.
        if (bus.push && dest_ok && !rx_push) begin
            rx_ovf_d = 1'b1;
        end else if (bus.clr_flags) begin
            rx_ovf_d = 1'b0;
        end
`ifdef DEST_CHECK_EN
        misroute_d = misroute_q;
        if (bus.push && !dest_ok) begin
            misroute_d = 1'b1;
        end else if (bus.clr_flags) begin
            misroute_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            rx_ovf_q    <= 1'b0;
`ifdef DEST_CHECK_EN
            misroute_q  <= 1'b0;
`endif
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_ovf_q    <= rx_ovf_d;
`ifdef DEST_CHECK_EN
            misroute_q  <= misroute_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= bus.D_push;
        end
    end

    assign bus.rx_valid = rx_nonempty;
    assign bus.rx_data  = rx_nonempty ? rx_mem_q[rx_rd_ptr_q] : '0;
    assign bus.rx_ovf   = rx_ovf_q;
`ifdef DEST_CHECK_EN
    assign bus.misroute = misroute_q;
`endif
endmodule

// File: doc/bus_port_fifo.md
Name: bus_port_fifo

Overview:
- Per-device port buffer between one device agent and the bus generator/arbiter (bs_gnrtr_n_rbtr); one instance per bus drvr.
- TX side: queues device packets and presents them to the arbiter via pndng/D_pop/pop.
- RX side: captures bus deliveries (push/D_push) into a receive queue that the device drains.
- Packet format pckg_sz bits: [pckg_sz-1:pckg_sz-8] destination ID, remainder payload.

Parameters:
- pckg_sz, 24, packet width in bits (16-bit payload + 8-bit destination ID).
- depth, 8, entries per FIFO (TX and RX each); power of two, >=2.
- id, 0, this port's device ID (8 bits).
- bc, 8'hFF, broadcast ID.

Ports:
- clk  in  1  bus clock, all logic on posedge.
- reset  in  1  asynchronous active-high reset.
- wr_en  in  1  device write strobe into TX FIFO.
- wr_data  in  pckg_sz  device packet.
- tx_full  out  1  TX FIFO holds depth entries.
- pndng  out  1  TX FIFO non-empty (to arbiter).
- D_pop  out  pckg_sz  TX head packet (to arbiter).
- pop  in  1  arbiter consumes TX head.
- push  in  1  bus delivers packet to this port.
- D_push  in  pckg_sz  delivered packet.
- rx_rd  in  1  device consumes RX head.
- rx_valid  out  1  RX FIFO non-empty.
- rx_data  out  pckg_sz  RX head packet.
- tx_ovf  out  1  sticky: TX write dropped.
- rx_ovf  out  1  sticky: RX delivery dropped.
- clr_flags  in  1  synchronous clear of sticky flags.

Behaviour:
- Reset is asynchronous and active-high: both FIFOs empty, pointers/counts 0; pndng=0, D_pop=0, tx_full=0, rx_valid=0, rx_data=0, tx_ovf=0, rx_ovf=0. Reset asserted mid-transfer discards all stored packets.
- Both FIFOs are first-word fall-through. Head data is valid whenever pndng/rx_valid=1. Outputs are 0 when the FIFO is empty.
- Write latency: a packet written in cycle N is visible on D_pop with pndng=1 in cycle N+1. RX side is the same: push in cycle N gives rx_valid=1 in N+1.
- pop with pndng=1: head is removed and the next entry appears in the following cycle. pop with pndng=0 is ignored, with no pointer change.
- wr_en with tx_full=0: accepted.
- wr_en with tx_full=1 and no pop: dropped, tx_ovf set next cycle, contents unchanged.
- wr_en with tx_full=1 and pop in the same cycle: accepted, count stays depth, no overflow.
- wr_en and pop while empty: write accepted, pop ignored, pndng=1 next cycle.
- RX has no backpressure toward the bus. push while RX is full (and no rx_rd) drops the packet and sets rx_ovf. push plus rx_rd while full is accepted.
- Pointers are log2(depth) bits and wrap modulo depth. Count is log2(depth)+1 bits.
- Full/empty are derived from count; tx_full is registered and consistent with count every cycle.
- clr_flags clears tx_ovf/rx_ovf next cycle. An overflow in the same cycle as clr_flags wins (flag stays 1).
- Packets are stored unmodified; D_pop equals the wr_data bits as written.

Optional Feature:
- Macro DEST_CHECK_EN.
- When defined: on push, D_push[pckg_sz-1:pckg_sz-8] is compared against id and bc.
  - Mismatch: packet is not stored, and added output misroute (1 bit, sticky, reset 0, cleared by clr_flags) is set next cycle.
  - Match: normal RX behaviour.
  - A misrouted packet never sets rx_ovf.
- When undefined: every push is stored regardless of ID, and the misroute port does not exist.

Test Plan:
- Reset then write 24'h03_ABCD -> next cycle pndng=1, D_pop=24'h03ABCD; pop -> next cycle pndng=0, D_pop=0.
- Write 8 packets 24'h01_0000..24'h01_0007, then a ninth write -> tx_full=1, ninth dropped, tx_ovf=1; 8 pops return 0000..0007 in order, wrap-around then verified with 4 more writes/pops.
- tx_full=1, wr_en=1 and pop=1 in the same cycle -> count stays 8, tx_ovf stays 0, new packet emerges after the 7 older ones.
- 9 pushes with no rx_rd -> rx_ovf=1, rx_data sequence is the first 8 packets; clr_flags -> rx_ovf=0 next cycle.
- Assert reset asynchronously mid-cycle with 5 TX entries -> pndng=0 and D_pop=0 immediately, before the next clk edge.
- DEST_CHECK_EN, id=2:
  - push 24'h05_1234 -> not stored, misroute=1.
  - push 24'hFF_5555 -> rx_data=24'hFF5555.
  - push 24'h02_0001 -> stored.
